prog_loader: RTL and testbench
==============================

# prog_loader

Byte-serial program loader that sits directly upstream of the single-cycle RISC-V core. It fills the core's writable instruction memory from a byte stream, verifies an XOR checksum, and holds the core in reset until a valid image has been written. It drives the instruction-memory write port and the core's reset input; the core fetches only after this block releases it.

## Interface
- ADDR_W, 6, instruction-memory word-address width; DEPTH = 2^ADDR_W words (64).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; returns the block to LEN0.
- byte_valid  in  1  source presents a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  block accepts byte this cycle; a transfer occurs when byte_valid && byte_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word to write.
- core_reset  out  1  drives the core's reset; high until the image is loaded and verified.
- done  out  1  image loaded, checksum matched.
- error  out  1  load failed (oversize count or checksum mismatch).

## Operation
- Stream format: N_lo, N_hi (16-bit word count N, little-endian), then 4·N data bytes, then one checksum byte.
- Each word is little-endian: the first byte goes to [7:0] and the fourth to [31:24]. Word k is written to imem_addr = k, with k starting at 0.
- The checksum equals the XOR of all 4·N data bytes; the two length bytes are excluded.
- States are LEN0, LEN1, DATA, CHECK, DONE, ERR, and the state is LEN0 while reset is asserted.
  - LEN0: accepting a byte stores N_lo and moves to LEN1.
  - LEN1: accepting a byte stores N_hi.
    - If N > DEPTH, go to ERR.
    - If N == 0, go to CHECK.
    - Otherwise go to DATA.
  - DATA: accept bytes with a 2-bit byte counter.
    - On the 4th byte the assembled word is registered into imem_wdata/imem_addr with imem_we = 1 for the next cycle, and the word counter increments.
    - After word N-1's 4th byte, go to CHECK.
  - CHECK: accept one byte. If it equals the running XOR, go to DONE; otherwise go to ERR.
  - DONE and ERR are terminal; only reset exits them.
- byte_ready is a combinational decode of state: 1 in LEN0/LEN1/DATA/CHECK, 0 in DONE/ERR.
- core_reset is registered: it is 1 in every state except DONE.
- done is 1 only in DONE; error is 1 only in ERR.
- The running XOR and the counters clear on reset.
- Bytes offered in DONE/ERR are ignored and never acknowledged.

## Timing
- Reset values: state LEN0, byte_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, done 0, error 0.
- Throughput is one byte per cycle with no wait states in LEN0..CHECK.
- Write latency:
  - A 4th byte accepted in cycle t produces imem_we = 1 in cycle t+1 only, with imem_addr/imem_wdata valid in that same cycle.
  - imem_addr/imem_wdata hold their values after the strobe.
- Back-to-back words: the next word's bytes may be accepted during the strobe cycle. The assembly register is separate from imem_wdata.
- Release timing:
  - The checksum byte is accepted in cycle c. done = 1 and core_reset = 0 take effect from the edge ending c.
  - The last imem_we occurs no later than cycle c, so the write has landed before the core leaves reset.
- Error timing: error rises on the edge that accepts the offending N_hi or checksum byte, and core_reset stays 1.
- Asserting reset mid-load:
  - All outputs immediately return to their reset values, including imem_we forced to 0 asynchronously.
  - The partial image is abandoned, and the next stream restarts at LEN0.
- byte_valid low stalls all states without losing any count or XOR state.

## Test plan
- Nominal: stream 02 00 13 00 00 00 93 00 A0 00 20 → two strobes: (addr 0, 0x00000013), then (addr 1, 0x00A00093); done = 1, core_reset = 0, error = 0; the core then executes addi x1, x0, 10.
- Bad checksum: same stream with final byte 21 → both writes occur; error = 1, done = 0, core_reset stays 1, byte_ready = 0.
- Oversize: stream 41 00 (N = 65 > 64) → ERR on the edge accepting 00; no imem_we ever; core_reset = 1.
- Empty image: stream 00 00 00 → CHECK is entered directly and the checksum 00 matches; done = 1 with zero writes.
- Stall/gaps: the nominal stream with byte_valid randomly deasserted 50% of cycles → identical writes and final state.
- Reset mid-load: assert reset after 6 bytes of the nominal stream, release it, then resend the full stream → outputs return to reset values during reset; final result matches the nominal test.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream handshake between the program source and the loader.
// The source drives valid/data; the loader answers with ready.
interface prog_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// Byte-serial program loader: fills instruction memory from a length-prefixed stream,
// verifies an XOR checksum and holds the core in reset until a valid image is in place.
module prog_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CHECK, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        xor_q, xor_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_reset_q, core_reset_d;
  logic              accept;
  logic [15:0]       n_full;

  assign bus.byte_ready = (state_q == LEN0) || (state_q == LEN1) ||
                          (state_q == DATA) || (state_q == CHECK);
  assign accept = bus.byte_valid && bus.byte_ready;
  assign n_full = {bus.byte_data, len_lo_q};

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    xor_d        = xor_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      LEN0: begin
        if (accept) begin
          len_lo_d = bus.byte_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          if (n_full > 16'(DEPTH)) begin
            state_d = ERR;
          end else if (n_full == 16'd0) begin
            state_d = CHECK;
          end else begin
            n_d     = n_full[ADDR_W:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = bus.byte_data;
            2'd1: asm_d[15:8]  = bus.byte_data;
            2'd2: asm_d[23:16] = bus.byte_data;
            default: begin
              // The fourth byte goes straight to the write port so assembly can resume next cycle.
              imem_we_d    = 1'b1;
              imem_addr_d  = word_cnt_q[ADDR_W-1:0];
              imem_wdata_d = {bus.byte_data, asm_q};
              word_cnt_d   = word_cnt_q + 1'b1;
              if (word_cnt_d == n_q) begin
                state_d = CHECK;
              end
            end
          endcase
        end
      end
      CHECK: begin
        if (accept) begin
          state_d = (bus.byte_data == xor_q) ? DONE : ERR;
        end
      end
      default: ;
    endcase

    core_reset_d = (state_d != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LEN0;
      len_lo_q     <= '0;
      n_q          <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      xor_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      xor_q        <= xor_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a stream-level model predicts every output each cycle,
// and literal expectations pin the nominal, checksum, oversize, empty, stall and reset cases.
module tb_prog_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  int errors = 0;
  int checks = 0;

  prog_loader_if bus ();

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Stream-level model: byte index within the stream decides what each accepted byte means.
  int          m_acc;
  int          m_term;
  int          m_n;
  logic [7:0]  m_lo;
  logic [7:0]  m_xor;
  logic [31:0] m_word;
  logic        m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_ok;

  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_acc   = 0;
    m_term  = 1 << 30;
    m_n     = 0;
    m_lo    = 8'h00;
    m_xor   = 8'h00;
    m_word  = 32'h0;
    m_we    = 1'b0;
    m_addr  = 6'd0;
    m_wdata = 32'h0;
    m_ok    = 1'b0;
  endtask

  task automatic modelAccept(input logic [7:0] b);
    int i;
    int j;
    i = m_acc;
    m_acc++;
    if (i == 0) begin
      m_lo = b;
    end else if (i == 1) begin
      m_n    = int'({b, m_lo});
      m_term = (m_n > DEPTH) ? 2 : 2 + 4 * m_n + 1;
    end else if (i < 2 + 4 * m_n) begin
      j = i - 2;
      m_word[(j % 4) * 8 +: 8] = b;
      m_xor = m_xor ^ b;
      if (j % 4 == 3) begin
        m_we    = 1'b1;
        m_addr  = 6'(j / 4);
        m_wdata = m_word;
      end
    end else begin
      m_ok = (b == m_xor);
    end
  endtask

  task automatic checkOutput();
    logic fin;
    logic exp_done;
    fin      = (m_acc >= m_term);
    exp_done = fin && (m_n <= DEPTH) && m_ok;
    checkValue("byte_ready", 32'(bus.byte_ready), 32'(!fin));
    checkValue("imem_we", 32'(imem_we), 32'(m_we));
    checkValue("imem_addr", 32'(imem_addr), 32'(m_addr));
    checkValue("imem_wdata", imem_wdata, m_wdata);
    checkValue("done", 32'(done), 32'(exp_done));
    checkValue("error", 32'(error), 32'(fin && !exp_done));
    checkValue("core_reset", 32'(core_reset), 32'(!exp_done));
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    logic acc;
    bus.byte_valid = v;
    bus.byte_data  = d;
    acc = v && (m_acc < m_term);
    @(posedge clk);
    #1;
    m_we = 1'b0;
    if (acc) modelAccept(d);
    checkOutput();
  endtask

  task automatic doReset();
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(posedge clk);
    #1;
    modelReset();
    checkOutput();
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] s[$], input int gap_pct);
    int idx;
    int cyc;
    logic v;
    idx = 0;
    cyc = 0;
    while (idx < s.size() && cyc < 500) begin
      v = ($urandom_range(99) >= gap_pct);
      cycle(v, v ? s[idx] : 8'($urandom_range(255)));
      if (v) idx++;
      cyc++;
    end
    checkValue("stream_timeout", 32'(idx), 32'(s.size()));
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00);
  endtask

  task automatic checkNominalResult(input string tag);
    checkValue({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      checkValue({tag, "_addr0"}, 32'(wr_addr[0]), 32'd0);
      checkValue({tag, "_data0"}, wr_data[0], 32'h0000_0013);
      checkValue({tag, "_addr1"}, 32'(wr_addr[1]), 32'd1);
      checkValue({tag, "_data1"}, wr_data[1], 32'h00A0_0093);
    end
    checkValue({tag, "_done"}, 32'(done), 32'd1);
    checkValue({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    checkValue({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    logic [7:0] nom[$]   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'hA0, 8'h00, 8'h20, 8'hFF};
    logic [7:0] bad[$]   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'hA0, 8'h00, 8'h21};
    logic [7:0] over[$]  = '{8'h41, 8'h00, 8'h01, 8'h02};
    logic [7:0] empty[$] = '{8'h00, 8'h00, 8'h00};

    modelReset();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    doReset();
    checkValue("reset_core_reset", 32'(core_reset), 32'd1);
    checkValue("reset_ready", 32'(bus.byte_ready), 32'd1);
    applyStimulus(nom, 0);
    checkNominalResult("nominal");
    checkValue("nominal_ready_after", 32'(bus.byte_ready), 32'd0);

    doReset();
    applyStimulus(bad, 0);
    checkValue("badsum_nwrites", 32'(wr_addr.size()), 32'd2);
    checkValue("badsum_error", 32'(error), 32'd1);
    checkValue("badsum_done", 32'(done), 32'd0);
    checkValue("badsum_core_reset", 32'(core_reset), 32'd1);
    checkValue("badsum_ready", 32'(bus.byte_ready), 32'd0);

    doReset();
    applyStimulus(over, 0);
    checkValue("oversize_nwrites", 32'(wr_addr.size()), 32'd0);
    checkValue("oversize_error", 32'(error), 32'd1);
    checkValue("oversize_core_reset", 32'(core_reset), 32'd1);

    doReset();
    applyStimulus(empty, 0);
    checkValue("empty_nwrites", 32'(wr_addr.size()), 32'd0);
    checkValue("empty_done", 32'(done), 32'd1);
    checkValue("empty_core_reset", 32'(core_reset), 32'd0);

    doReset();
    applyStimulus(nom, 50);
    checkNominalResult("stall");

    doReset();
    for (int i = 0; i < 6; i++) cycle(1'b1, nom[i]);
    checkValue("midreset_strobe_before", 32'(imem_we), 32'd1);
    reset = 1'b1;
    #1;
    checkValue("midreset_we", 32'(imem_we), 32'd0);
    checkValue("midreset_addr", 32'(imem_addr), 32'd0);
    checkValue("midreset_wdata", imem_wdata, 32'd0);
    checkValue("midreset_ready", 32'(bus.byte_ready), 32'd1);
    checkValue("midreset_core_reset", 32'(core_reset), 32'd1);
    checkValue("midreset_done", 32'(done), 32'd0);
    doReset();
    applyStimulus(nom, 0);
    checkNominalResult("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
